// File: rtl/bus_demux.sv
// ---------------------------------------------------------------------------
// bus_demux
//
// External-side bus interface for the tt_um_6502 pins. It reassembles the
// time-multiplexed 6502 address and data pins into one 16-bit bus cycle per
// CPU cycle, runs a req/ack handshake toward memory or a peripheral, and
// returns read data for the CPU data-input pins.
//
// High CPU phase : addr_mux_in carries A[15:8], data_mux_in carries write
//                  data, and data_oe_in == 8'hFF marks a write.
// Low CPU phase  : addr_mux_in carries A[7:0].
// On the next rising phase transition, the captured cycle is committed to
// the bus.
//
// Parameters
//   TIMEOUT    ack wait limit in clk cycles (1..255)
//   FILL_BYTE  read data returned when a cycle times out (6502 NOP)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cpu_phase           CPU phase level (1 = high phase), sync to clk
//   addr_mux_in         CPU uo_out pins
//   data_mux_in         CPU uio_out pins
//   data_oe_in          CPU uio_oe pins
//   mem_addr/wdata/we   registered bus cycle, stable while mem_req = 1
//   mem_req             request, held until ack or timeout
//   mem_ack, mem_rdata  single-clk acknowledge with read data
//   cpu_rdata           last completed read data (FILL_BYTE on timeout)
//   bus_err             one-clk pulse when a cycle times out
//   overrun             sticky flag: a CPU cycle was dropped
//   rd_count, wr_count  (BUS_STATS_EN only) saturating acked read/write counts
//
// Optional feature: define BUS_STATS_EN to add rd_count and wr_count.
// ---------------------------------------------------------------------------
module bus_demux #(
    parameter int         TIMEOUT   = 8,
    parameter logic [7:0] FILL_BYTE = 8'hEA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_phase,
    input  logic [7:0]  addr_mux_in,
    input  logic [7:0]  data_mux_in,
    input  logic [7:0]  data_oe_in,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  cpu_rdata,
    output logic        bus_err,
    output logic        overrun
`ifdef BUS_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_REQ  = 1'b1;

    // Last counter value before the cycle is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    // Phase capture registers
    logic [7:0]  hi_byte_q,   hi_byte_d;
    logic [7:0]  lo_byte_q,   lo_byte_d;
    logic [7:0]  wbyte_q,     wbyte_d;
    logic        wr_flag_q,   wr_flag_d;
    logic        hi_valid_q,  hi_valid_d;
    logic        phase_q,     phase_d;

    // Bus cycle registers
    logic        state_q,     state_d;
    logic [7:0]  cnt_q,       cnt_d;
    logic [15:0] mem_addr_q,  mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        mem_we_q,    mem_we_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic        bus_err_q,   bus_err_d;
    logic        overrun_q,   overrun_d;

    logic        commit;

`ifdef BUS_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;
`endif

    always_comb begin
        hi_byte_d   = hi_byte_q;
        lo_byte_d   = lo_byte_q;
        wbyte_d     = wbyte_q;
        wr_flag_d   = wr_flag_q;
        hi_valid_d  = hi_valid_q;
        phase_d     = cpu_phase;
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        cpu_rdata_d = cpu_rdata_q;
        bus_err_d   = 1'b0;
        overrun_d   = overrun_q;
`ifdef BUS_STATS_EN
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
`endif

        // A commit uses the bytes captured before this clk, so the new high
        // phase can be captured in the same clk without disturbing it.
        commit = cpu_phase && !phase_q && hi_valid_q;

        // The last sample of each phase wins.
        if (cpu_phase) begin
            hi_byte_d  = addr_mux_in;
            wbyte_d    = data_mux_in;
            wr_flag_d  = (data_oe_in == 8'hFF);
            hi_valid_d = 1'b1;
        end else begin
            lo_byte_d  = addr_mux_in;
        end

        case (state_q)
            ST_IDLE: begin
                // mem_ack is ignored here.
                if (commit) begin
                    state_d     = ST_REQ;
                    cnt_d       = 8'd0;
                    mem_addr_d  = {hi_byte_q, lo_byte_q};
                    mem_wdata_d = wbyte_q;
                    mem_we_d    = wr_flag_q;
                end
            end
            default: begin
                // There is no queue: a commit now drops that CPU cycle while
                // the outstanding request keeps its address and data.
                if (commit) begin
                    overrun_d = 1'b1;
                end
                // Ack takes priority over a timeout in the same clk.
                if (mem_ack) begin
                    state_d = ST_IDLE;
                    if (!mem_we_q) begin
                        cpu_rdata_d = mem_rdata;
                    end
`ifdef BUS_STATS_EN
                    if (!mem_we_q) begin
                        if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
                    end else begin
                        if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
                    end
`endif
                end else if (cnt_q == TO_LAST) begin
                    state_d   = ST_IDLE;
                    bus_err_d = 1'b1;
                    if (!mem_we_q) begin
                        cpu_rdata_d = FILL_BYTE;
                    end
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_byte_q   <= 8'h00;
            lo_byte_q   <= 8'h00;
            wbyte_q     <= 8'h00;
            wr_flag_q   <= 1'b0;
            hi_valid_q  <= 1'b0;
            phase_q     <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= 8'h00;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            mem_we_q    <= 1'b0;
            cpu_rdata_q <= FILL_BYTE;
            bus_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef BUS_STATS_EN
            rd_count_q  <= 16'h0000;
            wr_count_q  <= 16'h0000;
`endif
        end else begin
            hi_byte_q   <= hi_byte_d;
            lo_byte_q   <= lo_byte_d;
            wbyte_q     <= wbyte_d;
            wr_flag_q   <= wr_flag_d;
            hi_valid_q  <= hi_valid_d;
            phase_q     <= phase_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            cpu_rdata_q <= cpu_rdata_d;
            bus_err_q   <= bus_err_d;
            overrun_q   <= overrun_d;
`ifdef BUS_STATS_EN
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
`endif
        end
    end

    // mem_req comes straight from the state flop, so reset drops it at once.
    assign mem_req   = (state_q == ST_REQ);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign cpu_rdata = cpu_rdata_q;
    assign bus_err   = bus_err_q;
    assign overrun   = overrun_q;
`ifdef BUS_STATS_EN
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
`endif

endmodule

// File: tb/tb_bus_demux.sv
// ---------------------------------------------------------------------------
// tb_bus_demux
//
// Directed testbench for bus_demux (TIMEOUT = 8, FILL_BYTE = 8'hEA). The CPU
// pins are driven one phase at a time and the bus side is answered by hand.
// ---------------------------------------------------------------------------
module tb_bus_demux;

    logic        clk;
    logic        rst_n;
    logic        cpu_phase;
    logic [7:0]  addr_mux_in;
    logic [7:0]  data_mux_in;
    logic [7:0]  data_oe_in;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  cpu_rdata;
    logic        bus_err;
    logic        overrun;
`ifdef BUS_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    int vectors = 0;
    int errors  = 0;

    bus_demux #(.TIMEOUT(8), .FILL_BYTE(8'hEA)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_phase   (cpu_phase),
        .addr_mux_in (addr_mux_in),
        .data_mux_in (data_mux_in),
        .data_oe_in  (data_oe_in),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .cpu_rdata   (cpu_rdata),
        .bus_err     (bus_err),
        .overrun     (overrun)
`ifdef BUS_STATS_EN
        ,
        .rd_count    (rd_count),
        .wr_count    (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clk and settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full CPU cycle: high phase (continuing any current high phase),
    // then low phase. The data/oe pins carry junk in the low phase since
    // they must only be sampled in the high phase.
    task automatic drive_cycle(input logic [7:0] hi, input logic [7:0] dat,
                               input logic [7:0] oe, input logic [7:0] lo);
        cpu_phase   = 1'b1;
        addr_mux_in = hi;
        data_mux_in = dat;
        data_oe_in  = oe;
        tick();
        tick();
        cpu_phase   = 1'b0;
        addr_mux_in = lo;
        data_mux_in = 8'h99;
        data_oe_in  = ~oe;
        tick();
        tick();
    endtask

    // Rising phase transition: the commit clk. Phase then stays high.
    task automatic commit_edge();
        cpu_phase   = 1'b1;
        addr_mux_in = 8'h00;
        data_mux_in = 8'h00;
        data_oe_in  = 8'h00;
        tick();
    endtask

    task automatic ack_now(input logic [7:0] rd);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_phase = 1'b0; addr_mux_in = 8'h00; data_mux_in = 8'h00;
        data_oe_in = 8'h00; mem_ack = 1'b0; mem_rdata = 8'h00;
        #12;
        vectors++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
        vectors++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
        vectors++; if (mem_we !== 1'b0 || mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_we_wdata: got %b/%h want 0/00", mem_we, mem_wdata); end
        vectors++; if (cpu_rdata !== 8'hEA) begin errors++; $display("FAIL reset_rdata: got %h want ea", cpu_rdata); end
        vectors++; if (bus_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b/%b want 0/0", bus_err, overrun); end
`ifdef BUS_STATS_EN
        vectors++; if (rd_count !== 16'h0 || wr_count !== 16'h0) begin errors++; $display("FAIL reset_counts: got %h/%h want 0/0", rd_count, wr_count); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        int n;
        drive_cycle(8'h12, 8'h00, 8'h00, 8'h34);
        // The first rising transition after reset must not have committed.
        vectors++; if (mem_req !== 1'b0) begin errors++; $display("FAIL first_edge_no_commit: req %b want 0", mem_req); end
        commit_edge();
        vectors++; if (mem_req !== 1'b1) begin errors++; $display("FAIL read_req_rise: got %b want 1", mem_req); end
        vectors++; if (mem_addr !== 16'h1234 || mem_we !== 1'b0) begin errors++; $display("FAIL read_addr_we: got %h/%b want 1234/0", mem_addr, mem_we); end
        n = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (mem_req === 1'b1) n++;
        end
        ack_now(8'hA9);
        vectors++; if (mem_req !== 1'b0 || n != 3) begin errors++; $display("FAIL read_req_len: req %b high %0d clk want 0 and 3", mem_req, n); end
        vectors++; if (cpu_rdata !== 8'hA9) begin errors++; $display("FAIL read_rdata: got %h want a9", cpu_rdata); end
    endtask

    task automatic test_write();
        drive_cycle(8'h02, 8'h5C, 8'hFF, 8'h00);
        commit_edge();
        vectors++; if (mem_addr !== 16'h0200 || mem_we !== 1'b1 || mem_wdata !== 8'h5C) begin
            errors++; $display("FAIL write_cycle: got %h/%b/%h want 0200/1/5c", mem_addr, mem_we, mem_wdata); end
        tick();
        ack_now(8'h11);
        vectors++; if (mem_req !== 1'b0 || cpu_rdata !== 8'hA9) begin
            errors++; $display("FAIL write_no_rdata: req %b rdata %h want 0/a9", mem_req, cpu_rdata); end
    endtask

    task automatic test_timeout();
        int n, e;
        drive_cycle(8'hFF, 8'h00, 8'h00, 8'hFC);
        commit_edge();
        vectors++; if (mem_addr !== 16'hFFFC) begin errors++; $display("FAIL timeout_addr: got %h want fffc", mem_addr); end
        n = 0; e = 0;
        for (int i = 0; i < 12; i++) begin
            if (mem_req === 1'b1) n++;
            if (bus_err === 1'b1) e++;
            tick();
        end
        vectors++; if (n != 8) begin errors++; $display("FAIL timeout_req_len: got %0d want 8", n); end
        vectors++; if (e != 1) begin errors++; $display("FAIL timeout_bus_err: got %0d pulses want 1", e); end
        vectors++; if (cpu_rdata !== 8'hEA) begin errors++; $display("FAIL timeout_fill: got %h want ea", cpu_rdata); end
    endtask

    task automatic test_ack_vs_timeout();
        drive_cycle(8'h40, 8'h00, 8'h00, 8'h00);
        commit_edge();
        for (int i = 0; i < 7; i++) tick();
        ack_now(8'h5A);
        vectors++; if (bus_err !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL ack_wins: bus_err %b req %b want 0/0", bus_err, mem_req); end
        vectors++; if (cpu_rdata !== 8'h5A) begin errors++; $display("FAIL ack_wins_rdata: got %h want 5a", cpu_rdata); end
    endtask

    task automatic test_partial_oe();
        drive_cycle(8'h33, 8'h77, 8'h0F, 8'h44);
        commit_edge();
        vectors++; if (mem_addr !== 16'h3344 || mem_we !== 1'b0) begin errors++; $display("FAIL partial_oe: got %h/%b want 3344/0", mem_addr, mem_we); end
        ack_now(8'hC3);
        vectors++; if (cpu_rdata !== 8'hC3) begin errors++; $display("FAIL partial_oe_rdata: got %h want c3", cpu_rdata); end
    endtask

    task automatic test_idle_ack();
        mem_ack = 1'b1; mem_rdata = 8'h66;
        tick(); tick();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        vectors++; if (cpu_rdata !== 8'hC3 || mem_req !== 1'b0) begin errors++; $display("FAIL idle_ack: rdata %h req %b want c3/0", cpu_rdata, mem_req); end
    endtask

    task automatic test_overrun();
        drive_cycle(8'hAB, 8'h00, 8'h00, 8'hCD);
        commit_edge();
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", overrun); end
        cpu_phase = 1'b0; addr_mux_in = 8'h11;
        tick(); tick();
        cpu_phase = 1'b1; addr_mux_in = 8'h22; data_mux_in = 8'h33; data_oe_in = 8'hFF;
        tick();
        vectors++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
        vectors++; if (mem_addr !== 16'hABCD || mem_we !== 1'b0 || mem_req !== 1'b1) begin
            errors++; $display("FAIL overrun_hold: got %h/%b/%b want abcd/0/1", mem_addr, mem_we, mem_req); end
        ack_now(8'h77);
        vectors++; if (cpu_rdata !== 8'h77 || mem_addr !== 16'hABCD) begin errors++; $display("FAIL overrun_first: got %h/%h want 77/abcd", cpu_rdata, mem_addr); end
        tick(); tick(); tick();
        vectors++; if (mem_req !== 1'b0 || overrun !== 1'b1) begin errors++; $display("FAIL overrun_no_queue: req %b ovr %b want 0/1", mem_req, overrun); end
    endtask

`ifdef BUS_STATS_EN
    task automatic test_stats();
        // Acked so far: reads 1234, 4000, 3344, ABCD; write 0200.
        vectors++; if (rd_count !== 16'd4 || wr_count !== 16'd1) begin errors++; $display("FAIL stats_counts: got %0d/%0d want 4/1", rd_count, wr_count); end
        drive_cycle(8'h05, 8'hE1, 8'hFF, 8'h06);
        commit_edge();
        ack_now(8'h00);
        vectors++; if (wr_count !== 16'd2) begin errors++; $display("FAIL stats_wr: got %0d want 2", wr_count); end
        force dut.rd_count_q = 16'hFFFF;
        tick();
        release dut.rd_count_q;
        drive_cycle(8'h07, 8'h00, 8'h00, 8'h08);
        commit_edge();
        ack_now(8'h01);
        vectors++; if (rd_count !== 16'hFFFF) begin errors++; $display("FAIL stats_sat: got %h want ffff", rd_count); end
    endtask
`endif

    task automatic test_async_reset();
        drive_cycle(8'h50, 8'h00, 8'h00, 8'h60);
        commit_edge();
        tick();
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (mem_req !== 1'b0) begin errors++; $display("FAIL async_req: got %b want 0", mem_req); end
        vectors++; if (cpu_rdata !== 8'hEA || overrun !== 1'b0 || mem_addr !== 16'h0000) begin
            errors++; $display("FAIL async_state: rdata %h ovr %b addr %h want ea/0/0000", cpu_rdata, overrun, mem_addr); end
        #2 rst_n = 1'b1;
        // cpu_phase is still high: the first post-reset edge is a rising
        // transition with nothing captured, so it must not commit.
        tick();
        vectors++; if (mem_req !== 1'b0) begin errors++; $display("FAIL post_reset_no_commit: got %b want 0", mem_req); end
        drive_cycle(8'h9A, 8'h00, 8'h00, 8'hBC);
        commit_edge();
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 16'h9ABC) begin errors++; $display("FAIL post_reset_commit: req %b addr %h want 1/9abc", mem_req, mem_addr); end
        ack_now(8'h42);
        vectors++; if (cpu_rdata !== 8'h42) begin errors++; $display("FAIL post_reset_rdata: got %h want 42", cpu_rdata); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_ack_vs_timeout();
        test_partial_oe();
        test_idle_ack();
        test_overrun();
`ifdef BUS_STATS_EN
        test_stats();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
